// File: rtl/nand_sched_pkg.sv
// nand_sched_pkg
//   Shared definitions for the NAND operation scheduler: FSM state encoding,
//   operation codes, per-requester status codes and small helper functions
//   for status resolution, one-hot enable decoding and round-robin stepping.
package nand_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_RUN   = 3'd2,
    S_FIN   = 3'd3,
    S_GAP   = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    OP_WR = 2'd0,
    OP_RD = 2'd1,
    OP_ER = 2'd2
  } op_t;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_BAD  = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;
  localparam logic [1:0] ST_TO   = 2'd3;

  // Round-robin successor: WR -> RD -> ER -> WR.
  function automatic op_t next_op(input op_t op);
    case (op)
      OP_WR:   return OP_RD;
      OP_RD:   return OP_ER;
      OP_ER:   return OP_WR;
      default: return OP_WR;
    endcase
  endfunction

  // One-hot vector {ER, RD, WR} for an operation code.
  function automatic logic [2:0] op_onehot(input op_t op);
    case (op)
      OP_WR:   return 3'b001;
      OP_RD:   return 3'b010;
      OP_ER:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Completion status for an operation that ended with its end_* pulse.
  // A bad block dominates; an erase reporting error code 1 is still a pass.
  function automatic logic [1:0] calc_status(input op_t        op,
                                             input logic [1:0] addr_err,
                                             input logic [1:0] wr_success,
                                             input logic [1:0] ecc_state);
    logic [1:0] st;
    st = ST_OK;
    if (addr_err == 2'd2) begin
      st = ST_BAD;
    end else begin
      case (op)
        OP_WR:   st = (wr_success != 2'd1) ? ST_FAIL : ST_OK;
        OP_RD:   st = (ecc_state == 2'd3) ? ST_FAIL : ST_OK;
        OP_ER:   st = ST_OK;
        default: st = ST_OK;
      endcase
    end
    return st;
  endfunction

endpackage

// File: rtl/nand_rr_arbiter.sv
// nand_rr_arbiter
//   Three-way round-robin arbiter. The grant is combinational from the
//   request vector and the registered pointer; the pointer moves to the
//   requester after the winner whenever the grant is consumed.
// Ports
//   clk        controller clock
//   rst        asynchronous active-low reset (pointer returns to WR)
//   req[2:0]   level requests {ER, RD, WR}
//   adv        grant consumed this cycle; advance the pointer
//   gnt_valid  at least one request present
//   gnt_op     winning operation
module nand_rr_arbiter
  import nand_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       adv,
  output logic       gnt_valid,
  output op_t        gnt_op
);

  op_t ptr_r;
  op_t cand1_s;
  op_t cand2_s;

  // Pick the first requester at or after the pointer.
  always_comb begin
    cand1_s   = next_op(ptr_r);
    cand2_s   = next_op(cand1_s);
    gnt_valid = |req;
    if (|(req & op_onehot(ptr_r))) begin
      gnt_op = ptr_r;
    end else if (|(req & op_onehot(cand1_s))) begin
      gnt_op = cand1_s;
    end else if (|(req & op_onehot(cand2_s))) begin
      gnt_op = cand2_s;
    end else begin
      gnt_op = ptr_r;
    end
  end

  // Pointer update: the requester after the winner gets first chance next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= OP_WR;
    end else if (adv) begin
      ptr_r <= next_op(gnt_op);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/nand_op_scheduler.sv
// nand_op_scheduler
//   Arbitrates page-write, page-read and block-erase requests onto the single
//   NAND controller port set. One operation at a time: the request address is
//   latched, the matching enable is held until its end_* pulse, a watchdog
//   flag or a timeout, then a 2-bit status is returned to the requester.
//   A forced idle gap separates consecutive enables.
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   {wr,rd,er}_req/_addr          level request and row address per requester
//   {wr,rd,er}_ack                1-cycle accept pulse (address sampled then)
//   {wr,rd,er}_done/_status       1-cycle completion pulse with status
//   en_write_page/en_read/en_erase_page   controller enables, one-hot or zero
//   write/read/erase_addr_row     latched address of the active operation
//   end_*, *_addr_row_error, write_success, read_data_ECCstate,
//   nandflash_busy_Noresponse     controller results
//   sched_busy                    high from grant until the gap expires
module nand_op_scheduler
  import nand_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 60000,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        er_req,
  input  logic [23:0] wr_addr,
  input  logic [23:0] rd_addr,
  input  logic [23:0] er_addr,
  output logic        wr_ack,
  output logic        rd_ack,
  output logic        er_ack,
  output logic        wr_done,
  output logic        rd_done,
  output logic        er_done,
  output logic [1:0]  wr_status,
  output logic [1:0]  rd_status,
  output logic [1:0]  er_status,
  output logic        en_write_page,
  output logic        en_read,
  output logic        en_erase_page,
  output logic [23:0] write_addr_row,
  output logic [23:0] read_addr_row,
  output logic [23:0] erase_addr_row,
  input  logic        end_write_page,
  input  logic        end_read,
  input  logic        end_erase_page,
  input  logic [1:0]  write_addr_row_error,
  input  logic [1:0]  read_addr_row_error,
  input  logic [1:0]  erase_addr_row_error,
  input  logic [1:0]  write_success,
  input  logic [1:0]  read_data_ECCstate,
  input  logic        nandflash_busy_Noresponse,
  output logic        sched_busy
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  sched_state_t      state_r;
  op_t               sel_op_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic [2:0]        ack_r;
  logic [2:0]        done_r;
  logic [2:0]        en_r;
  logic [1:0]        wr_status_r;
  logic [1:0]        rd_status_r;
  logic [1:0]        er_status_r;
  logic [23:0]       wr_row_r;
  logic [23:0]       rd_row_r;
  logic [23:0]       er_row_r;
  logic              busy_r;

  logic              gnt_valid_s;
  op_t               gnt_op_s;
  logic              adv_s;
  logic              end_sel_s;
  logic [1:0]        err_sel_s;
  logic              to_hit_s;
  logic              exit_s;
  logic [1:0]        status_s;

  assign adv_s = (state_r == S_IDLE) && gnt_valid_s;

  nand_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({er_req, rd_req, wr_req}),
    .adv       (adv_s),
    .gnt_valid (gnt_valid_s),
    .gnt_op    (gnt_op_s)
  );

  // Route the completion pulse and bad-block code of the selected op only;
  // end_* of the other ops never reaches the FSM.
  always_comb begin
    end_sel_s = 1'b0;
    err_sel_s = 2'b00;
    case (sel_op_r)
      OP_WR: begin
        end_sel_s = end_write_page;
        err_sel_s = write_addr_row_error;
      end
      OP_RD: begin
        end_sel_s = end_read;
        err_sel_s = read_addr_row_error;
      end
      OP_ER: begin
        end_sel_s = end_erase_page;
        err_sel_s = erase_addr_row_error;
      end
      default: begin
        end_sel_s = 1'b0;
        err_sel_s = 2'b00;
      end
    endcase
  end

  // Exit condition and resulting status. A real end_* in the terminal-count
  // cycle reports the controller's result; the watchdog flag always aborts.
  always_comb begin
    to_hit_s = (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
    exit_s   = end_sel_s | to_hit_s | nandflash_busy_Noresponse;
    if (nandflash_busy_Noresponse || (to_hit_s && !end_sel_s)) begin
      status_s = ST_TO;
    end else begin
      status_s = calc_status(sel_op_r, err_sel_s, write_success, read_data_ECCstate);
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      sel_op_r    <= OP_WR;
      to_cnt_r    <= '0;
      gap_cnt_r   <= '0;
      ack_r       <= 3'b000;
      done_r      <= 3'b000;
      en_r        <= 3'b000;
      wr_status_r <= ST_OK;
      rd_status_r <= ST_OK;
      er_status_r <= ST_OK;
      wr_row_r    <= 24'h000000;
      rd_row_r    <= 24'h000000;
      er_row_r    <= 24'h000000;
      busy_r      <= 1'b0;
    end else begin
      ack_r  <= 3'b000;
      done_r <= 3'b000;
      case (state_r)
        S_IDLE: begin
          if (gnt_valid_s) begin
            sel_op_r <= gnt_op_s;
            ack_r    <= op_onehot(gnt_op_s);
            busy_r   <= 1'b1;
            state_r  <= S_GRANT;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_GRANT: begin
          // Address is sampled while *_ack is visible to the requester.
          case (sel_op_r)
            OP_WR:   wr_row_r <= wr_addr;
            OP_RD:   rd_row_r <= rd_addr;
            OP_ER:   er_row_r <= er_addr;
            default: wr_row_r <= wr_row_r;
          endcase
          to_cnt_r <= '0;
          en_r     <= op_onehot(sel_op_r);
          state_r  <= S_RUN;
        end
        S_RUN: begin
          if (exit_s) begin
            en_r   <= 3'b000;
            done_r <= op_onehot(sel_op_r);
            case (sel_op_r)
              OP_WR:   wr_status_r <= status_s;
              OP_RD:   rd_status_r <= status_s;
              OP_ER:   er_status_r <= status_s;
              default: wr_status_r <= wr_status_r;
            endcase
            state_r <= S_FIN;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
            state_r  <= S_RUN;
          end
        end
        S_FIN: begin
          gap_cnt_r <= '0;
          state_r   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt_r == GAP_W'(GAP_CYC - 1)) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            state_r   <= S_GAP;
          end
        end
        default: begin
          en_r    <= 3'b000;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_ack         = ack_r[0];
  assign rd_ack         = ack_r[1];
  assign er_ack         = ack_r[2];
  assign wr_done        = done_r[0];
  assign rd_done        = done_r[1];
  assign er_done        = done_r[2];
  assign wr_status      = wr_status_r;
  assign rd_status      = rd_status_r;
  assign er_status      = er_status_r;
  assign en_write_page  = en_r[0];
  assign en_read        = en_r[1];
  assign en_erase_page  = en_r[2];
  assign write_addr_row = wr_row_r;
  assign read_addr_row  = rd_row_r;
  assign erase_addr_row = er_row_r;
  assign sched_busy     = busy_r;

endmodule
